// File: rtl/cond_resolver.sv
// cond_resolver: resolves ARM-style condition codes against status flags, stalling on in-flight flag writes.
// Optional statistics counters are enabled by defining COND_RESOLVER_STATS_EN.
module cond_resolver #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             negative_flag,
    input  logic             zero_flag,
    input  logic             carry_flag,
    input  logic             overflow_flag,
    input  logic             mode_flag,
    input  logic [2:0]       update_mode,
    input  logic             req_valid,
    input  logic [3:0]       req_cond,
    output logic             req_ready,
    output logic             res_valid,
    output logic             res_taken,
    output logic             halted,
    output logic [CNT_W-1:0] eval_count,
    output logic [CNT_W-1:0] taken_count
);
    typedef enum logic [1:0] {IDLE, WAIT, HALTED} state_t;

    state_t     state, state_n;
    logic [3:0] cond_q, cond_n;
    logic       valid_n, taken_n;

    function automatic logic cond_true(input logic [3:0] c, input logic n, z, cf, v, m);
        case (c)
            4'h0: cond_true = z;
            4'h1: cond_true = !z;
            4'h2: cond_true = cf;
            4'h3: cond_true = !cf;
            4'h4: cond_true = n;
            4'h5: cond_true = !n;
            4'h6: cond_true = v;
            4'h7: cond_true = !v;
            4'h8: cond_true = cf && !z;
            4'h9: cond_true = !cf || z;
            4'hA: cond_true = n == v;
            4'hB: cond_true = n != v;
            4'hC: cond_true = !z && (n == v);
            4'hD: cond_true = z || (n != v);
            4'hE: cond_true = 1'b1;
            default: cond_true = m;
        endcase
    endfunction

    assign req_ready = state == IDLE;
    assign halted    = state == HALTED;

    always_comb begin
        state_n = state;
        cond_n  = cond_q;
        valid_n = 1'b0;
        taken_n = res_taken;
        if (update_mode == 3'd6) begin
            state_n = HALTED;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    cond_n = req_cond;
                    if (update_mode == 3'd0) begin
                        valid_n = 1'b1;
                        taken_n = cond_true(req_cond, negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag);
                    end else begin
                        state_n = WAIT;
                    end
                end
                // Flags written at the intervening negedge are now stable.
                WAIT: begin
                    valid_n = 1'b1;
                    taken_n = cond_true(cond_q, negative_flag, zero_flag, carry_flag, overflow_flag, mode_flag);
                    state_n = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cond_q    <= 4'h0;
            res_valid <= 1'b0;
            res_taken <= 1'b0;
        end else begin
            state     <= state_n;
            cond_q    <= cond_n;
            res_valid <= valid_n;
            res_taken <= taken_n;
        end
    end

`ifdef COND_RESOLVER_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            eval_count  <= '0;
            taken_count <= '0;
        end else if (res_valid && state != HALTED) begin
            if (eval_count != '1)
                eval_count <= eval_count + 1'b1;
            if (res_taken && taken_count != '1)
                taken_count <= taken_count + 1'b1;
        end
    end
`else
    assign eval_count  = '0;
    assign taken_count = '0;
`endif
endmodule

// File: tb/tb_cond_resolver.sv
// tb_cond_resolver: directed self-checking bench for cond_resolver.
module tb_cond_resolver;
    localparam int CNT_W = 4;

    logic clock = 1'b0, reset = 1'b1;
    logic negative_flag = 0, zero_flag = 0, carry_flag = 0, overflow_flag = 0, mode_flag = 0;
    logic [2:0] update_mode = 3'd0;
    logic req_valid = 0;
    logic [3:0] req_cond = 4'h0;
    logic req_ready, res_valid, res_taken, halted;
    logic [CNT_W-1:0] eval_count, taken_count;
    int tests = 0, fails = 0;

    cond_resolver #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .negative_flag(negative_flag), .zero_flag(zero_flag), .carry_flag(carry_flag),
        .overflow_flag(overflow_flag), .mode_flag(mode_flag), .update_mode(update_mode),
        .req_valid(req_valid), .req_cond(req_cond), .req_ready(req_ready),
        .res_valid(res_valid), .res_taken(res_taken), .halted(halted),
        .eval_count(eval_count), .taken_count(taken_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flags(input logic n, z, c, v, m);
        negative_flag = n; zero_flag = z; carry_flag = c; overflow_flag = v; mode_flag = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 0;
        update_mode = 3'd0;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({req_ready, res_valid, res_taken, halted} !== 4'b1000) begin
            fails++;
            $display("FAIL reset: ready/valid/taken/halted=%b expected 1000", {req_ready, res_valid, res_taken, halted});
        end
        tests++;
        if (eval_count !== 0 || taken_count !== 0) begin
            fails++;
            $display("FAIL reset_counts: eval=%0d taken=%0d expected 0 0", eval_count, taken_count);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_eq_ne();
        set_flags(0, 1, 0, 0, 0);
        req_valid = 1; req_cond = 4'h0;
        tick();
        tests++;
        if (res_valid !== 1 || res_taken !== 1) begin
            fails++;
            $display("FAIL eq: valid=%b taken=%b expected 1 1", res_valid, res_taken);
        end
        req_cond = 4'h1;
        tick();
        tests++;
        if (res_valid !== 1 || res_taken !== 0) begin
            fails++;
            $display("FAIL ne: valid=%b taken=%b expected 1 0", res_valid, res_taken);
        end
        req_valid = 0;
        tick();
        tests++;
        if (res_valid !== 0 || res_taken !== 0) begin
            fails++;
            $display("FAIL idle_hold: valid=%b taken=%b expected 0 0", res_valid, res_taken);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] conds [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic       exp   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        set_flags(1, 0, 0, 0, 0);
        req_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req_cond = conds[i];
            tick();
            tests++;
            if (res_valid !== 1 || res_taken !== exp[i] || req_ready !== 1) begin
                fails++;
                $display("FAIL b2b[%0d]: valid=%b taken=%b ready=%b expected 1 %b 1", i, res_valid, res_taken, req_ready, exp[i]);
            end
        end
        req_valid = 0;
        tick();
    endtask

    task automatic test_wait();
        set_flags(0, 0, 0, 0, 0);
        req_valid = 1; req_cond = 4'h2; update_mode = 3'd2;
        tick();
        req_valid = 0; update_mode = 3'd0;
        tests++;
        if (req_ready !== 0 || res_valid !== 0) begin
            fails++;
            $display("FAIL wait_stall: ready=%b valid=%b expected 0 0", req_ready, res_valid);
        end
        @(negedge clock);
        carry_flag = 1;
        tick();
        tests++;
        if (res_valid !== 1 || res_taken !== 1 || req_ready !== 1) begin
            fails++;
            $display("FAIL wait_result: valid=%b taken=%b ready=%b expected 1 1 1", res_valid, res_taken, req_ready);
        end
        tick();
        tests++;
        if (res_valid !== 0) begin
            fails++;
            $display("FAIL wait_pulse: valid=%b expected 0", res_valid);
        end
    endtask

    task automatic test_mode_always();
        set_flags(0, 0, 0, 0, 0);
        req_valid = 1; req_cond = 4'hF;
        tick();
        tests++;
        if (res_valid !== 1 || res_taken !== 0) begin
            fails++;
            $display("FAIL ms_user: valid=%b taken=%b expected 1 0", res_valid, res_taken);
        end
        mode_flag = 1;
        tick();
        tests++;
        if (res_valid !== 1 || res_taken !== 1) begin
            fails++;
            $display("FAIL ms_super: valid=%b taken=%b expected 1 1", res_valid, res_taken);
        end
        set_flags(0, 0, 0, 0, 0); req_cond = 4'h1;
        tick();
        req_cond = 4'hE; set_flags(1, 1, 1, 1, 1);
        tick();
        tests++;
        if (res_valid !== 1 || res_taken !== 1) begin
            fails++;
            $display("FAIL al: valid=%b taken=%b expected 1 1", res_valid, res_taken);
        end
        req_valid = 0;
        tick();
    endtask

    task automatic test_halt();
        int bad = 0;
        set_flags(0, 0, 0, 0, 0);
        req_valid = 1; req_cond = 4'hE; update_mode = 3'd1;
        tick();
        req_valid = 0; update_mode = 3'd6;
        tick();
        update_mode = 3'd0;
        tests++;
        if (halted !== 1 || res_valid !== 0 || req_ready !== 0) begin
            fails++;
            $display("FAIL halt_enter: halted=%b valid=%b ready=%b expected 1 0 0", halted, res_valid, req_ready);
        end
        req_valid = 1; req_cond = 4'hE;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (halted !== 1 || res_valid !== 0 || req_ready !== 0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_sticky: %0d bad cycles expected 0", bad);
        end
        #2 reset = 1;
        #1;
        tests++;
        if (halted !== 0 || req_ready !== 1 || res_valid !== 0) begin
            fails++;
            $display("FAIL async_reset: halted=%b ready=%b valid=%b expected 0 1 0", halted, req_ready, res_valid);
        end
        reset = 0; req_valid = 0;
        tick();
    endtask

    task automatic test_stats();
        logic [CNT_W-1:0] exp_e, exp_t;
        do_reset();
        set_flags(0, 0, 0, 0, 0);
        req_valid = 1; req_cond = 4'hE;
        repeat (3) tick();
        req_cond = 4'h0;
        repeat (2) tick();
        req_valid = 0;
        tick();
`ifdef COND_RESOLVER_STATS_EN
        exp_e = 5; exp_t = 3;
`else
        exp_e = 0; exp_t = 0;
`endif
        tests++;
        if (eval_count !== exp_e || taken_count !== exp_t) begin
            fails++;
            $display("FAIL stats_mid: eval=%0d taken=%0d expected %0d %0d", eval_count, taken_count, exp_e, exp_t);
        end
        do_reset();
        req_valid = 1; req_cond = 4'hE;
        repeat (20) tick();
        req_valid = 0;
        tick();
`ifdef COND_RESOLVER_STATS_EN
        exp_e = 15; exp_t = 15;
`endif
        tests++;
        if (eval_count !== exp_e || taken_count !== exp_t) begin
            fails++;
            $display("FAIL stats_sat: eval=%0d taken=%0d expected %0d %0d", eval_count, taken_count, exp_e, exp_t);
        end
    endtask

    initial begin
        test_reset();
        test_eq_ne();
        test_back_to_back();
        test_wait();
        test_mode_always();
        test_halt();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cond_resolver.md
Name: cond_resolver

Overview:
- Consumer side of the processor status-flag register. Reads N/Z/C/V/mode flags and resolves a 4-bit condition code for conditional branches and conditional execution.
- Uses a valid/ready request handshake and returns a registered taken/not-taken result.
- Snoops the flag-register update bus. It stalls when a flag write is in flight and enters a sticky halted state when the HALT update is seen.
- Sits in the control unit between the instruction decoder and the PC-select logic.

Parameters:
- CNT_W, 16, width of the saturating statistics counters (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- negative_flag  in  1  N flag from status register.
- zero_flag  in  1  Z flag.
- carry_flag  in  1  C flag.
- overflow_flag  in  1  V flag.
- mode_flag  in  1  supervisor-mode flag.
- update_mode  in  3  flag-register update code in flight this cycle (0 = none, 6 = HALT).
- req_valid  in  1  condition-evaluation request.
- req_cond  in  4  condition code, sampled on acceptance.
- req_ready  out  1  block can accept a request.
- res_valid  out  1  one-cycle pulse; res_taken valid.
- res_taken  out  1  condition result.
- halted  out  1  sticky halt indication.
- eval_count  out  CNT_W  requests resolved (optional feature).
- taken_count  out  CNT_W  requests resolved taken (optional feature).

Behaviour:
- Reset: async, active-high, overrides everything. State=IDLE, res_valid=0, res_taken=0, halted=0, counters=0, captured cond=0.
- States: IDLE, WAIT, HALTED. req_ready=1 only in IDLE.
- Acceptance: posedge with state=IDLE and req_valid=1. req_cond is captured at that edge.
- IDLE, accept, update_mode=0:
  - res_taken is computed from the flags sampled at the same edge.
  - res_valid=1 for the following cycle (latency 1). State stays IDLE.
  - Back-to-back requests are accepted every cycle.
- IDLE, accept, update_mode in 1..5:
  - A flag write commits at the intervening negedge, so the block goes to WAIT and evaluates at the next posedge using the new flags.
  - res_valid is asserted in the cycle after that (latency 2). The block then returns to IDLE.
- WAIT: evaluation is unconditional, and update_mode is not re-checked except for HALT.
- update_mode=6 at any posedge, in any state (with or without req_valid):
  - Next state=HALTED, halted=1.
  - A request accepted at that edge or pending in WAIT is dropped; no res_valid is produced.
- HALTED is terminal until reset: req_ready=0, res_valid=0, halted=1.
- res_valid is a single-cycle pulse. There is no backpressure on the result, and the consumer must take it.
- res_taken holds its last value when res_valid=0.
- Condition encoding (ARM-style):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F MS: mode_flag (supervisor-only execution)
- req_valid while req_ready=0 is ignored, not queued. The requester must hold it.

Optional Feature:
- Macro: COND_RESOLVER_STATS_EN.
- Defined:
  - eval_count increments on every res_valid pulse.
  - taken_count increments on every res_valid pulse with res_taken=1.
  - Both saturate at all-ones (no wrap), are frozen in HALTED, and are cleared only by reset.
- Undefined: counter logic is omitted; eval_count and taken_count are driven constant 0. All other behaviour is unchanged.

Test Plan:
- Flags N=0 Z=1 C=0 V=0, update_mode=0, req_cond=0 (EQ) at edge 1 -> res_valid=1, res_taken=1 in cycle 2. Same with req_cond=1 -> res_taken=0.
- Back-to-back GE/LT/GT/LE requests on 4 consecutive cycles with N=1 V=0 Z=0 -> results 0,1,0,1 on 4 consecutive res_valid pulses, req_ready held 1.
- update_mode=2 at acceptance of req_cond=2 (CS); flags change C 0->1 at the negedge -> req_ready=0 one cycle, then res_valid=1 with res_taken=1 at latency 2.
- update_mode=6 while in WAIT -> no res_valid, halted=1, req_ready=0 held for 20 cycles. Async reset mid-cycle -> halted=0, req_ready=1 immediately.
- req_cond=F with mode_flag=0 then 1 -> res_taken 0 then 1. req_cond=E -> 1 regardless of flags.
- With COND_RESOLVER_STATS_EN and CNT_W=4: 20 AL requests -> eval_count=15, taken_count=15 (saturated). Without the macro, both read 0.
